// File: rtl/mon_host_link.sv
// Host end of the monitor serial link: 40-bit frame TX/RX, full duplex.
// Optional even parity bit in both directions: define MON_LINK_PARITY_EN.
module mon_host_link #(
  parameter int DATA_W   = 40,
  parameter int BIT_CLKS = 4,
  parameter int GAP_BITS = 2
) (
  input  logic              mon_clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              to_mon,
  input  logic              from_mon,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              tx_busy
);

`ifdef MON_LINK_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int BW = $clog2(DATA_W + GAP_BITS + 1);
  localparam logic [CW-1:0] C_LAST = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] C_MID  = CW'(BIT_CLKS / 2);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] G_LAST = BW'(GAP_BITS - 1);

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA, T_PAR, T_STOP, T_GAP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA, R_PAR, R_STOP
  } rx_state_t;

  tx_state_t         tx_st, tx_nx;
  logic [CW-1:0]     tx_cyc, tx_cyc_nx;
  logic [BW-1:0]     tx_bit, tx_bit_nx;
  logic [DATA_W-1:0] tx_sh, tx_sh_nx;
  logic              tx_par, tx_par_nx;
  logic              tx_end;

  rx_state_t         rx_st, rx_nx;
  logic [CW-1:0]     rx_cyc, rx_cyc_nx;
  logic [BW-1:0]     rx_bit, rx_bit_nx;
  logic [DATA_W-1:0] rx_sh, rx_sh_nx;
  logic              rx_pb, rx_pb_nx;
  logic [DATA_W-1:0] rx_data_nx;
  logic              rx_valid_nx, rx_err_nx;
  logic              armed, armed_nx;
  logic              s1, s2, prev;
  logic              rx_mid, rx_last;

  // TX state register
  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st  <= T_IDLE;
      tx_cyc <= '0;
      tx_bit <= '0;
      tx_sh  <= '0;
      tx_par <= 1'b0;
    end else begin
      tx_st  <= tx_nx;
      tx_cyc <= tx_cyc_nx;
      tx_bit <= tx_bit_nx;
      tx_sh  <= tx_sh_nx;
      tx_par <= tx_par_nx;
    end
  end

  // TX next state; the line level is decoded from state so reset idles it at once
  always_comb begin
    tx_nx     = tx_st;
    tx_cyc_nx = tx_cyc;
    tx_bit_nx = tx_bit;
    tx_sh_nx  = tx_sh;
    tx_par_nx = tx_par;
    tx_ready  = 1'b0;
    to_mon    = 1'b1;
    tx_end    = (tx_cyc == C_LAST);
    if (tx_st != T_IDLE)
      tx_cyc_nx = tx_end ? '0 : tx_cyc + 1'b1;
    unique case (tx_st)
      T_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          tx_nx     = T_START;
          tx_sh_nx  = tx_data;
          tx_par_nx = ^tx_data;
          tx_cyc_nx = '0;
          tx_bit_nx = '0;
        end
      end
      T_START: begin
        to_mon = 1'b0;
        if (tx_end) tx_nx = T_DATA;
      end
      T_DATA: begin
        to_mon = tx_sh[DATA_W-1];
        if (tx_end) begin
          tx_sh_nx = {tx_sh[DATA_W-2:0], 1'b0};
          if (tx_bit == B_LAST) begin
            tx_bit_nx = '0;
            tx_nx     = PAR_EN ? T_PAR : T_STOP;
          end else begin
            tx_bit_nx = tx_bit + 1'b1;
          end
        end
      end
      T_PAR: begin
        to_mon = tx_par;
        if (tx_end) tx_nx = T_STOP;
      end
      T_STOP: begin
        if (tx_end)
          tx_nx = (GAP_BITS > 0) ? T_GAP : T_IDLE;
      end
      T_GAP: begin
        if (tx_end) begin
          if (tx_bit == G_LAST) begin
            tx_bit_nx = '0;
            tx_nx     = T_IDLE;
          end else begin
            tx_bit_nx = tx_bit + 1'b1;
          end
        end
      end
      default: tx_nx = T_IDLE;
    endcase
  end

  assign tx_busy = ~tx_ready;

  // from_mon synchronizer plus one-cycle history for falling-edge detect
  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= from_mon;
      s2   <= s1;
      prev <= s2;
    end
  end

  // RX state register and registered outputs
  always_ff @(posedge mon_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st    <= R_IDLE;
      rx_cyc   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_pb    <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      armed    <= 1'b1;
    end else begin
      rx_st    <= rx_nx;
      rx_cyc   <= rx_cyc_nx;
      rx_bit   <= rx_bit_nx;
      rx_sh    <= rx_sh_nx;
      rx_pb    <= rx_pb_nx;
      rx_data  <= rx_data_nx;
      rx_valid <= rx_valid_nx;
      rx_err   <= rx_err_nx;
      armed    <= armed_nx;
    end
  end

  // RX next state; the edge cycle counts as cycle 0 of the start bit
  always_comb begin
    rx_nx       = rx_st;
    rx_cyc_nx   = rx_cyc;
    rx_bit_nx   = rx_bit;
    rx_sh_nx    = rx_sh;
    rx_pb_nx    = rx_pb;
    rx_data_nx  = rx_data;
    rx_valid_nx = 1'b0;
    rx_err_nx   = 1'b0;
    armed_nx    = armed | s2;
    rx_mid      = (rx_cyc == C_MID);
    rx_last     = (rx_cyc == C_LAST);
    if (rx_st != R_IDLE)
      rx_cyc_nx = rx_last ? '0 : rx_cyc + 1'b1;
    unique case (rx_st)
      R_IDLE: begin
        if (armed && prev && !s2) begin
          rx_nx     = R_START;
          rx_cyc_nx = C_ONE;
          rx_bit_nx = '0;
        end
      end
      R_START: begin
        if (rx_mid && s2) begin
          rx_nx = R_IDLE;
        end else if (rx_last) begin
          rx_nx = R_DATA;
        end
      end
      R_DATA: begin
        if (rx_mid)
          rx_sh_nx = {rx_sh[DATA_W-2:0], s2};
        if (rx_last) begin
          if (rx_bit == B_LAST) begin
            rx_bit_nx = '0;
            rx_nx     = PAR_EN ? R_PAR : R_STOP;
          end else begin
            rx_bit_nx = rx_bit + 1'b1;
          end
        end
      end
      R_PAR: begin
        if (rx_mid) rx_pb_nx = s2;
        if (rx_last) rx_nx = R_STOP;
      end
      R_STOP: begin
        if (rx_mid) begin
          rx_nx = R_IDLE;
          if (s2 && (!PAR_EN || (rx_pb == ^rx_sh))) begin
            rx_valid_nx = 1'b1;
            rx_data_nx  = rx_sh;
          end else begin
            rx_err_nx = 1'b1;
            armed_nx  = 1'b0;
          end
        end
      end
      default: rx_nx = R_IDLE;
    endcase
  end

endmodule
